// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester: one valid/ready command in, one APB transfer out, one response back
module apb_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    // command from fabric
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    // response to fabric
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    // APB bus
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    // A zero TIMEOUT disables the abort path; keep the counter at least one bit wide
    // so the declaration stays legal in that case.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;

    // Wait-state budget is exhausted on this ACCESS cycle if pready does not rescue it.
    logic w_timeout_hit;
    assign w_timeout_hit = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    // Ready is a pure decode of the state so upstream sees no path from cmd_valid.
    assign cmd_ready = (r_state == IDLE);

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Transfer sequencer: all bus and response outputs are produced from registers here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Address/data registers are only reloaded on acceptance, so they
                    // keep the last driven values while the bus is idle.
                    if (cmd_valid) begin
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= cmd_write;
                        r_paddr   <= cmd_addr;
                        r_pwdata  <= cmd_write ? cmd_wdata : '0;
                        r_state   <= SETUP;
                    end
                end

                SETUP: begin
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                    r_state   <= ACCESS;
                end

                ACCESS: begin
                    // pready takes priority over the timeout on the same cycle.
                    if (pready) begin
                        r_rsp_rdata <= r_pwrite ? '0 : prdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_state     <= RESP;
                    end else if (TIMEOUT != 0) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (w_timeout_hit) begin
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_psel      <= 1'b0;
                            r_penable   <= 1'b0;
                            r_state     <= RESP;
                        end
                    end
                end

                RESP: begin
                    // Data and error flag persist after the handshake until the next response.
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
